cache4w_ctrl: RTL and testbench

Sequencing controller for the 4-way set-associative, write-through word cache.
- Owns the tag, valid and data arrays and one replacement state per set.
- Accepts single-word read/write requests from a CPU-side requester and resolves hits in the arrays.
- Issues handshaked single-word transactions to backing RAM for refills and write-through.
- Sits between the processor datapath and the main-memory model.

---
 rtl/cache4w_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cache4w_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache4w_ctrl.sv
// cache4w_ctrl: sequencing controller for a 4-way set-associative, write-through word cache.
// Replacement is a round-robin pointer per set by default, tree pseudo-LRU with CACHE_PLRU_EN.
module cache4w_ctrl #(
  parameter int unsigned SETS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_done_o,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_hit_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam int unsigned IndexW = $clog2(SETS);
  localparam int unsigned TagW   = 30 - IndexW;
`ifdef CACHE_PLRU_EN
  localparam int unsigned ReplW  = 3;
`else
  localparam int unsigned ReplW  = 2;
`endif

  typedef enum logic [2:0] {StIdle, StLookup, StMemRd, StMemWr, StResp} state_e;
  state_e state_q, state_d;

  logic [TagW-1:0]  tag_q   [SETS][4];
  logic [31:0]      data_q  [SETS][4];
  logic [3:0]       valid_q [SETS];
  logic [ReplW-1:0] repl_q  [SETS];

  logic        we_q, we_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        hit_q, hit_d;
  logic [1:0]  way_q, way_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:2] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`ifndef CACHE_PLRU_EN
  logic        evict_q, evict_d;
`endif

  logic [1:0]  unused_addr_bits;
  assign unused_addr_bits = cpu_addr_i[1:0];

  logic [IndexW-1:0] idx;
  logic [TagW-1:0]   tag;
  logic [3:0]        hit_vec;
  logic [1:0]        hit_way, free_way, policy_way, lookup_way, arr_way;
  logic              hit_any, all_valid, arr_we, repl_we;
  logic [31:0]       arr_data;
  logic [ReplW-1:0]  repl_cur, repl_d;

  assign idx = addr_q[IndexW+1:2];
  assign tag = addr_q[31:IndexW+2];

  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    free_way = '0;
    for (int w = 0; w < 4; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (hit_vec[w]) hit_way = 2'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = 3; w >= 0; w--) begin
      if (!valid_q[idx][w]) free_way = 2'(w);
    end
  end

  assign hit_any   = |hit_vec;
  assign all_valid = &valid_q[idx];
  assign repl_cur  = repl_q[idx];

`ifdef CACHE_PLRU_EN
  assign policy_way = repl_cur[0] ? {1'b1, repl_cur[2]} : {1'b0, repl_cur[1]};

  function automatic logic [2:0] plru_touch(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] r;
    r = s;
    unique case (w)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction
`else
  assign policy_way = repl_cur;
`endif

  assign lookup_way = hit_any ? hit_way : (all_valid ? policy_way : free_way);

  // Arrays are written either at the end of LOOKUP (writes) or on the refill ack.
  always_comb begin
    arr_we   = ((state_q == StLookup) && we_q) || ((state_q == StMemRd) && mem_ack_i);
    arr_way  = (state_q == StLookup) ? lookup_way : way_q;
    arr_data = (state_q == StLookup) ? wdata_q : mem_rdata_i;
`ifdef CACHE_PLRU_EN
    repl_we  = arr_we || ((state_q == StLookup) && !we_q && hit_any);
    repl_d   = plru_touch(repl_cur, arr_way);
`else
    repl_we  = ((state_q == StLookup) && we_q && !hit_any && all_valid) ||
               ((state_q == StMemRd) && mem_ack_i && evict_q);
    repl_d   = repl_cur + 2'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[idx][arr_way]  <= tag;
      data_q[idx][arr_way] <= arr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        repl_q[s]  <= '0;
      end
    end else begin
      if (arr_we)  valid_q[idx][arr_way] <= 1'b1;
      if (repl_we) repl_q[idx] <= repl_d;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu_req_i) state_d = StLookup;
      StLookup: state_d = we_q ? StMemWr : (hit_any ? StResp : StMemRd);
      StMemRd:  if (mem_ack_i) state_d = StResp;
      StMemWr:  if (mem_ack_i) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    way_d       = way_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifndef CACHE_PLRU_EN
    evict_d     = evict_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i[31:2];
          wdata_d = cpu_wdata_i;
        end
      end
      StLookup: begin
        hit_d = hit_any;
        way_d = lookup_way;
`ifndef CACHE_PLRU_EN
        evict_d = !hit_any && all_valid;
`endif
        if (we_q) begin
          rdata_d     = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
        end else if (hit_any) begin
          rdata_d = data_q[idx][hit_way];
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = addr_q;
        end
      end
      StMemRd: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          rdata_d   = mem_rdata_i;
        end
      end
      StMemWr: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      way_q       <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifndef CACHE_PLRU_EN
      evict_q     <= 1'b0;
`endif
    end else begin
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      way_q       <= way_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifndef CACHE_PLRU_EN
      evict_q     <= evict_d;
`endif
    end
  end

  // Outputs.
  always_comb begin
    cpu_done_o  = 1'b0;
    cpu_hit_o   = 1'b0;
    if (state_q == StResp) begin
      cpu_done_o = 1'b1;
      cpu_hit_o  = hit_q;
    end
    cpu_rdata_o = rdata_q;
    mem_req_o   = mem_req_q;
    mem_we_o    = mem_we_q;
    mem_addr_o  = {mem_addr_q, 2'b00};
    mem_wdata_o = mem_wdata_q;
  end

endmodule

// File: tb/tb_cache4w_ctrl.sv
// Self-checking bench for cache4w_ctrl: directed vector table plus hand-written corner sequences.
// Expectations follow the round-robin policy unless CACHE_PLRU_EN is defined.
module tb_cache4w_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_done, cpu_hit;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  cache4w_ctrl #(.SETS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req_i  (cpu_req),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_wdata_i(cpu_wdata),
    .cpu_done_o (cpu_done),
    .cpu_rdata_o(cpu_rdata),
    .cpu_hit_o  (cpu_hit),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_ack_i  (mem_ack),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    else pass_cnt++;
  endtask

  // Memory model: acks after ack_delay cycles of mem_req; driven on the falling edge.
  int          ack_delay = 1;
  int          ack_cnt = 0;
  int          tx_cnt = 0;
  int          done_cnt = 0;
  int          req_cycles = 0;
  logic [31:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [31:0] mem_m [4096];
  bit          mem_inited = 1'b0;

  always @(negedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 4096; i++) mem_m[i] = '0;
      mem_m[16] = 32'd111;
      mem_inited = 1'b1;
    end
    if (!rst_n) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else begin
      if (cpu_done) done_cnt++;
      if (mem_req) req_cycles++;
      if (mem_ack) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (mem_req) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          tx_cnt++;
          last_addr = mem_addr;
          last_we   = mem_we;
          if (mem_we) mem_m[mem_addr[13:2]] = mem_wdata;
          else        mem_rdata = mem_m[mem_addr[13:2]];
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_hit;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_tx;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic hit, input logic [31:0] rdata, input int lat,
                              input int tx);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_hit = hit; v.exp_rdata = rdata; v.exp_lat = lat; v.exp_tx = tx;
    return v;
  endfunction

  // One request from an idle controller; lat counts edges from the sampling edge to cpu_done.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic hit, output logic [31:0] rdata, output int lat,
                         output logic ok);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_done) ok = 1'b1;
    end
    hit = cpu_hit; rdata = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  logic        hit, ok, stable, seen;
  logic [31:0] rdata;
  int          lat, tx0, d0, rc0, dc;

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", cpu_done, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", cpu_done, 0);
    chk("post_rst_mem_req", mem_req, 0);

    vecs.push_back(mk(0, 64,   0,    0, 111, 3, 1));
    vecs.push_back(mk(0, 64,   0,    1, 111, 2, 0));
    vecs.push_back(mk(1, 64,   111,  1, 0,   3, 1));
    vecs.push_back(mk(1, 1088, 222,  0, 0,   3, 1));
    vecs.push_back(mk(1, 3136, 333,  0, 0,   3, 1));
    vecs.push_back(mk(1, 7232, 444,  0, 0,   3, 1));
    vecs.push_back(mk(0, 64,   0,    1, 111, 2, 0));
    vecs.push_back(mk(0, 1088, 0,    1, 222, 2, 0));
    vecs.push_back(mk(0, 3136, 0,    1, 333, 2, 0));
    vecs.push_back(mk(0, 7232, 0,    1, 444, 2, 0));
    vecs.push_back(mk(0, 64,   0,    1, 111, 2, 0));
    vecs.push_back(mk(1, 2112, 5000, 0, 0,   3, 1));
`ifdef CACHE_PLRU_EN
    vecs.push_back(mk(0, 3136, 0,    0, 333, 3, 1));
    vecs.push_back(mk(0, 64,   0,    1, 111, 2, 0));
`else
    vecs.push_back(mk(0, 64,   0,    0, 111, 3, 1));
`endif
    vecs.push_back(mk(0, 2112, 0,    1, 5000, 2, 0));

    foreach (vecs[i]) begin
      tx0 = tx_cnt;
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, hit, rdata, lat, ok);
      chk($sformatf("v%0d_done", i), ok, 1);
      chk($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_mem_tx", i), tx_cnt - tx0, vecs[i].exp_tx);
      if (vecs[i].exp_tx > 0) begin
        chk($sformatf("v%0d_mem_addr", i), last_addr, vecs[i].addr);
        chk($sformatf("v%0d_mem_we", i), last_we, vecs[i].we);
      end
    end

    // Slow memory: request must stay stable, inputs ignored while busy, exactly one done.
    ack_delay = 5;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 256; cpu_wdata = 77;
    rc0 = req_cycles; d0 = done_cnt; stable = 1'b1; seen = 1'b0; lat = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      cpu_we = 1'b0; cpu_addr = 512; cpu_wdata = 99;
      if (mem_req && (mem_addr != 256 || mem_wdata != 77 || !mem_we)) stable = 1'b0;
      if (cpu_done) seen = 1'b1;
    end
    cpu_req = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("slow_done_seen", seen, 1);
    chk("slow_latency", lat, 7);
    chk("slow_req_cycles", req_cycles - rc0, 5);
    chk("slow_done_count", done_cnt - d0, 1);
    chk("slow_req_stable", stable, 1);
    ack_delay = 1;
    run_req(0, 256, 0, hit, rdata, lat, ok);
    chk("slow_readback_hit", hit, 1);
    chk("slow_readback_rdata", rdata, 77);

    // Back-to-back hits with cpu_req held: one completion every 3 cycles.
    tx0 = tx_cnt; dc = 0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (cpu_done) begin
        chk("b2b_cycle", c, 2 + 3 * dc);
        chk("b2b_hit", cpu_hit, 1);
        chk("b2b_rdata", cpu_rdata, 111);
        dc++;
      end
    end
    cpu_req = 1'b0;
    chk("b2b_count", dc, 4);
    chk("b2b_no_mem", tx_cnt - tx0, 0);

    // Reset while a refill is outstanding.
    ack_delay = 5;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 768;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (mem_req) seen = 1'b1;
    end
    chk("rstmid_req_seen", seen, 1);
    @(posedge clk); #3;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("rstmid_req_drop", mem_req, 0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_idle_req", mem_req, 0);
    ack_delay = 1;
    run_req(0, 64, 0, hit, rdata, lat, ok);
    chk("rstmid_read_done", ok, 1);
    chk("rstmid_read_hit", hit, 0);
    chk("rstmid_read_rdata", rdata, 111);
    chk("rstmid_read_lat", lat, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
